// File: rtl/shift_register_ctrl.sv
// Button-driven bidirectional shift register: debounced left/right/load buttons with
// fill/rotate/arithmetic modes. Define SHIFT_REGISTER_AUTOREPEAT_EN for held-button auto-repeat.
module shift_register_ctrl #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_PERIOD   = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             button_left,
  input  logic             button_right,
  input  logic             button_load,
  input  logic             serial_left,
  input  logic             serial_right,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data_out,
  output logic             all_ones,
  output logic             all_zeros
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  if (WIDTH < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("shift_register_ctrl: illegal parameter value");
  end

  logic [2:0] btn_raw;
  logic [2:0] btn_event;

  assign btn_raw = {button_load, button_right, button_left};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic            sync1_q, sync2_q, level_q, level_prev_q, event_q;
    logic [CntW-1:0] cnt_q;
    logic            press;
    logic            rep_fire;

    // Press is a debounced 1->0 seen one cycle late, so the event register adds one more stage
    assign press = level_prev_q & ~level_q;

    always_ff @(posedge clock) begin
      if (!reset) begin
        sync1_q      <= 1'b1;
        sync2_q      <= 1'b1;
        level_q      <= 1'b1;
        level_prev_q <= 1'b1;
        event_q      <= 1'b0;
        cnt_q        <= '0;
      end else begin
        sync1_q      <= btn_raw[i];
        sync2_q      <= sync1_q;
        level_prev_q <= level_q;
        event_q      <= press | rep_fire;
        if (sync2_q == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

`ifdef SHIFT_REGISTER_AUTOREPEAT_EN
    if (i < 2) begin : g_rep
      localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                      : REPEAT_PERIOD;
      localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;

      logic [RepW-1:0] hold_cnt_q;
      logic            hold_active_q;
      logic            first_q;

      // First repeat waits REPEAT_DELAY after the press event, later ones REPEAT_PERIOD
      assign rep_fire = hold_active_q & ~level_q &
                        (hold_cnt_q == (first_q ? RepW'(REPEAT_DELAY - 1)
                                                : RepW'(REPEAT_PERIOD - 1)));

      always_ff @(posedge clock) begin
        if (!reset) begin
          hold_active_q <= 1'b0;
          first_q       <= 1'b0;
          hold_cnt_q    <= '0;
        end else if (press) begin
          hold_active_q <= 1'b1;
          first_q       <= 1'b1;
          hold_cnt_q    <= '0;
        end else if (hold_active_q) begin
          if (level_q) begin
            hold_active_q <= 1'b0;
          end else if (rep_fire) begin
            first_q    <= 1'b0;
            hold_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
      end
    end else begin : g_norep
      assign rep_fire = 1'b0;
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign btn_event[i] = event_q;
  end

  logic             ev_left, ev_right, ev_load;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] shifted;

  assign ev_left  = btn_event[0];
  assign ev_right = btn_event[1];
  assign ev_load  = btn_event[2];

  always_comb begin
    shifted = data_q;
    if (ev_left) begin
      case (mode)
        2'b00:   shifted = {data_q[WIDTH-2:0], serial_left};
        2'b01:   shifted = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        2'b11:   shifted = {data_q[WIDTH-2:0], 1'b0};
        default: shifted = data_q;
      endcase
    end else begin
      case (mode)
        2'b00:   shifted = {serial_right, data_q[WIDTH-1:1]};
        2'b01:   shifted = {data_q[0], data_q[WIDTH-1:1]};
        2'b11:   shifted = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        default: shifted = data_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      data_q <= '0;
    end else if (ev_load) begin
      data_q <= load_data;
    end else if (ev_left ^ ev_right) begin
      data_q <= shifted;
    end
  end

  assign data_out  = data_q;
  assign all_ones  = &data_q;
  assign all_zeros = ~|data_q;

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Directed bench for shift_register_ctrl (WIDTH=8, D=4, repeat 20/5); define
// SHIFT_REGISTER_AUTOREPEAT_EN for both bench and RTL to exercise auto-repeat.
module tb_shift_register_ctrl;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 5;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [2:0]   btn   = 3'b111;  // {load, right, left}, active-low
  logic         serial_left = 1'b0, serial_right = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] load_data = '0;
  logic [W-1:0] data_out;
  logic         all_ones, all_zeros;

  int n_checks = 0;
  int n_errors = 0;

  shift_register_ctrl #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .button_left (btn[0]),
    .button_right(btn[1]),
    .button_load (btn[2]),
    .serial_left (serial_left),
    .serial_right(serial_right),
    .mode        (mode),
    .load_data   (load_data),
    .data_out    (data_out),
    .all_ones    (all_ones),
    .all_zeros   (all_zeros)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on falling edges only
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic [2:0] mask);
    btn = ~mask;
    tick(D + 6);
    btn = 3'b111;
    tick(D + 6);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  int          n_chg;
  int          chg_at [$];
  logic [W-1:0] prev;

  initial begin
    // 1. reset and fill-mode left shifts with latency check
    tick(3);
    check_eq("rst_data", data_out, 8'h00);
    check_eq("rst_zeros", all_zeros, 1'b1);
    check_eq("rst_ones", all_ones, 1'b0);
    reset = 1'b1;
    mode = 2'b00;
    serial_left = 1'b1;
    btn = 3'b110;
    tick(D + 3);
    check_eq("lat_before", data_out, 8'h00);
    tick(1);
    check_eq("lat_at", data_out, 8'h01);
    tick(2);
    btn = 3'b111;
    tick(D + 6);
    press(3'b001);
    check_eq("fill_2", data_out, 8'h03);
    press(3'b001);
    check_eq("fill_3", data_out, 8'h07);

    // 2. short glitch ignored, bounce yields one shift
    btn = 3'b110; tick(3); btn = 3'b111; tick(10);
    check_eq("glitch", data_out, 8'h07);
    btn = 3'b110; tick(2); btn = 3'b111; tick(1);
    btn = 3'b110; tick(2); btn = 3'b111; tick(1);
    press(3'b001);
    check_eq("bounce", data_out, 8'h0F);

    // 3. rotate and arithmetic
    load_data = 8'h81;
    press(3'b100);
    check_eq("load_81", data_out, 8'h81);
    mode = 2'b01;
    press(3'b010);
    check_eq("rot_right", data_out, 8'hC0);
    mode = 2'b11;
    load_data = 8'h80;
    press(3'b100);
    press(3'b010);
    check_eq("asr_80", data_out, 8'hC0);
    press(3'b001);
    check_eq("asl_C0", data_out, 8'h80);

    // 4. priority, hold mode, status flags, boundaries
    press(3'b011);
    check_eq("cancel", data_out, 8'h80);
    load_data = 8'h5A;
    press(3'b101);
    check_eq("load_prio", data_out, 8'h5A);
    mode = 2'b10;
    press(3'b001);
    check_eq("hold_mode", data_out, 8'h5A);
    check_eq("ones_at_5A", all_ones, 1'b0);
    load_data = 8'hFF;
    press(3'b100);
    check_eq("ones_at_FF", all_ones, 1'b1);
    check_eq("zeros_at_FF", all_zeros, 1'b0);
    mode = 2'b11;
    press(3'b010);
    check_eq("asr_ff", data_out, 8'hFF);
    mode = 2'b00;
    serial_right = 1'b0;
    press(3'b010);
    check_eq("fill_right", data_out, 8'h7F);

    // 5. reset mid-debounce, then held across reset release
    serial_left = 1'b1;
    btn = 3'b110; tick(3);
    reset = 1'b0; tick(2);
    check_eq("rst_mid", data_out, 8'h00);
    btn = 3'b111; tick(1);
    reset = 1'b1; tick(12);
    check_eq("no_stale", data_out, 8'h00);
    btn = 3'b110; tick(3);
    reset = 1'b0; tick(2);
    reset = 1'b1;
    tick(D + 3);
    check_eq("held_rst_pre", data_out, 8'h00);
    tick(1);
    check_eq("held_rst_at", data_out, 8'h01);
`ifndef SHIFT_REGISTER_AUTOREPEAT_EN
    tick(20);
    check_eq("held_once", data_out, 8'h01);
`endif
    btn = 3'b111;
    tick(D + 6);

    // 6. long hold: one event, or repeats at +RD then every RP with the macro
    do_reset();
    load_data = 8'h01;
    press(3'b100);
    check_eq("load_01", data_out, 8'h01);
    mode = 2'b01;
    prev = data_out;
    n_chg = 0;
    btn = 3'b110;
    for (int c = 1; c <= 90; c++) begin
      tick(1);
      if (data_out !== prev) begin
        n_chg++;
        chg_at.push_back(c);
        prev = data_out;
      end
      if (c == 60) btn = 3'b111;
    end
    check_eq("first_at", (chg_at.size() > 0) ? chg_at[0] : -1, D + 4);
`ifdef SHIFT_REGISTER_AUTOREPEAT_EN
    check_eq("rep_count", n_chg, 9);
    check_eq("rep_delay", (chg_at.size() > 1) ? chg_at[1] - chg_at[0] : -1, RD);
    check_eq("rep_period", (chg_at.size() > 2) ? chg_at[2] - chg_at[1] : -1, RP);
    check_eq("rep_last", (chg_at.size() > 0) ? chg_at[chg_at.size()-1] : -1, 63);
    check_eq("rep_final", data_out, 8'h02);
`else
    check_eq("single_count", n_chg, 1);
    check_eq("single_final", data_out, 8'h02);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
